// File: rtl/aes_key_expand_rk10.sv
// Iterative AES-128 forward key schedule producing round key 10 for the decrypt core.
// Optional tap ports (round_key_tap, round_key_idx) are enabled by the macro AES_KEY_TAP_EN.

module aes_key_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            p = p ^ aa;
         end else begin
            p = p;
         end
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0), then the FIPS-197 affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] s;
      logic [7:0] b;
      r = 8'h01;
      s = x;
      for (int i = 0; i < 7; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      b = r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Purely combinational substitution.
   always_comb begin
      dout = sbox(din);
   end

endmodule

module aes_key_expand_rk10 #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [127:0] cipher_key,
   input  logic         key_new_en,
   input  logic         EN,
   output logic [127:0] round_key_10,
   output logic         key_ready,
   output logic         busy
`ifdef AES_KEY_TAP_EN
   ,
   output logic [127:0] round_key_tap,
   output logic [3:0]   round_key_idx
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(NR - 1);

   state_t         state_r, state_s;
   logic [3:0]     cnt_r, cnt_s;
   logic [7:0]     rcon_r, rcon_s;
   logic [127:0]   key_r, key_s;
   logic [127:0]   rk10_r, rk10_s;
   logic           key_ready_r, key_ready_s;
   logic           busy_r, busy_s;

   logic [31:0]    w0_s, w1_s, w2_s, w3_s;
   logic [31:0]    sub_s, temp_s;
   logic [31:0]    n0_s, n1_s, n2_s, n3_s;
   logic [127:0]   next_key_s;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
   endfunction

   assign w0_s = key_r[127:96];
   assign w1_s = key_r[95:64];
   assign w2_s = key_r[63:32];
   assign w3_s = key_r[31:0];

   // SubWord(RotWord(w3)): byte k of the rotated word is byte k+1 of w3.
   aes_key_sbox u_sbox0 (.din(w3_s[23:16]), .dout(sub_s[31:24]));
   aes_key_sbox u_sbox1 (.din(w3_s[15:8]),  .dout(sub_s[23:16]));
   aes_key_sbox u_sbox2 (.din(w3_s[7:0]),   .dout(sub_s[15:8]));
   aes_key_sbox u_sbox3 (.din(w3_s[31:24]), .dout(sub_s[7:0]));

   assign temp_s     = sub_s ^ {rcon_r, 24'h000000};
   assign n0_s       = w0_s ^ temp_s;
   assign n1_s       = w1_s ^ n0_s;
   assign n2_s       = w2_s ^ n1_s;
   assign n3_s       = w3_s ^ n2_s;
   assign next_key_s = {n0_s, n1_s, n2_s, n3_s};

   // Next-state and datapath update; EN=0 holds every register.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      rcon_s      = rcon_r;
      key_s       = key_r;
      rk10_s      = rk10_r;
      key_ready_s = key_ready_r;
      busy_s      = busy_r;
      if (EN) begin
         case (state_r)
            IDLE, DONE: begin
               if (key_new_en) begin
                  key_s       = cipher_key;
                  cnt_s       = 4'd0;
                  rcon_s      = 8'h01;
                  busy_s      = 1'b1;
                  key_ready_s = 1'b0;
                  state_s     = EXPAND;
               end else begin
                  state_s     = state_r;
               end
            end
            EXPAND: begin
               key_s  = next_key_s;
               cnt_s  = cnt_r + 4'd1;
               rcon_s = xtime(rcon_r);
               if (cnt_r == LAST_CNT) begin
                  rk10_s      = next_key_s;
                  key_ready_s = 1'b1;
                  busy_s      = 1'b0;
                  state_s     = DONE;
               end else begin
                  state_s     = EXPAND;
               end
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         rcon_r      <= 8'h01;
         key_r       <= 128'd0;
         rk10_r      <= 128'd0;
         key_ready_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         rcon_r      <= rcon_s;
         key_r       <= key_s;
         rk10_r      <= rk10_s;
         key_ready_r <= key_ready_s;
         busy_r      <= busy_s;
      end
   end

   assign round_key_10 = rk10_r;
   assign key_ready    = key_ready_r;
   assign busy         = busy_r;

`ifdef AES_KEY_TAP_EN
   assign round_key_tap = key_r;
   assign round_key_idx = cnt_r;
`endif

endmodule

// File: tb/tb_aes_key_expand_rk10.sv
// Directed bench for aes_key_expand_rk10: FIPS-197 key vectors plus EN, restart and reset corner cases.
// Tap checks are compiled in when AES_KEY_TAP_EN is defined.

module tb_aes_key_expand_rk10;

   logic         clk;
   logic         reset_n;
   logic [127:0] cipher_key;
   logic         key_new_en;
   logic         EN;
   logic [127:0] round_key_10;
   logic         key_ready;
   logic         busy;
`ifdef AES_KEY_TAP_EN
   logic [127:0] round_key_tap;
   logic [3:0]   round_key_idx;
`endif

   int n_vec;
   int n_err;

   typedef struct {
      logic [127:0] key;
      logic [127:0] rk1;
      logic [127:0] rk10;
   } vec_t;

   vec_t vecs [3];

   aes_key_expand_rk10 dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cipher_key   (cipher_key),
      .key_new_en   (key_new_en),
      .EN           (EN),
      .round_key_10 (round_key_10),
      .key_ready    (key_ready),
      .busy         (busy)
`ifdef AES_KEY_TAP_EN
      ,
      .round_key_tap(round_key_tap),
      .round_key_idx(round_key_idx)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; the load edge happens inside, returns at the following negedge.
   task automatic start_key(input logic [127:0] key);
      cipher_key = key;
      key_new_en = 1'b1;
      @(negedge clk);
      key_new_en = 1'b0;
      check("busy_after_load", {127'd0, busy}, 128'd1);
`ifdef AES_KEY_TAP_EN
      check("tap_idx0", {124'd0, round_key_idx}, 128'd0);
      check("tap_key0", round_key_tap, key);
`endif
   endtask

   // Steps 10 EN=1 edges after the load edge, checking exact latency and result.
   task automatic wait_result(input string name, input logic [127:0] rk1, input logic [127:0] rk10);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
`ifdef AES_KEY_TAP_EN
         check("tap_idx", {124'd0, round_key_idx}, 128'(i));
         if (i == 1) check("tap_rk1", round_key_tap, rk1);
         else        check("tap_rk1_unused", 128'd0, 128'd0 ^ {127'd0, 1'b0});
`endif
         if (i == 9) begin
            check({name, "_ready_early"}, {127'd0, key_ready}, 128'd0);
            check({name, "_busy_e9"}, {127'd0, busy}, 128'd1);
         end
      end
      check({name, "_ready"}, {127'd0, key_ready}, 128'd1);
      check({name, "_busy_done"}, {127'd0, busy}, 128'd0);
      check({name, "_rk10"}, round_key_10, rk10);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                  128'h13111d7fe3944a17f307a78b4d2b30c5};
      vecs[2] = '{128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
                  128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      reset_n    = 1'b0;
      cipher_key = 128'd0;
      key_new_en = 1'b0;
      EN         = 1'b1;
      #12;
      check("rst_rk10", round_key_10, 128'd0);
      check("rst_ready", {127'd0, key_ready}, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven key vectors back to back (each restart is from DONE).
      for (int v = 0; v < 3; v++) begin
         start_key(vecs[v].key);
         wait_result("vec", vecs[v].rk1, vecs[v].rk10);
      end

      // EN toggling: 10 EN=1 edges spread over 20 clocks.
      start_key(vecs[0].key);
      for (int i = 0; i < 20; i++) begin
         EN = (i % 2 == 1);
         @(negedge clk);
         if (i == 18) check("en_ready_early", {127'd0, key_ready}, 128'd0);
         if (i == 18) check("en_busy_held", {127'd0, busy}, 128'd1);
      end
      EN = 1'b1;
      check("en_ready", {127'd0, key_ready}, 128'd1);
      check("en_rk10", round_key_10, vecs[0].rk10);

      // EN=0 blocks a restart request in DONE.
      EN         = 1'b0;
      cipher_key = vecs[1].key;
      key_new_en = 1'b1;
      @(negedge clk);
      key_new_en = 1'b0;
      EN         = 1'b1;
      check("en0_ready_held", {127'd0, key_ready}, 128'd1);
      check("en0_busy_held", {127'd0, busy}, 128'd0);

      // Re-pulse while busy with another key is ignored.
      start_key(vecs[0].key);
      repeat (3) @(negedge clk);
      cipher_key = vecs[2].key;
      key_new_en = 1'b1;
      @(negedge clk);
      key_new_en = 1'b0;
      repeat (5) @(negedge clk);
      check("busy_ready_early", {127'd0, key_ready}, 128'd0);
      @(negedge clk);
      check("busy_ready", {127'd0, key_ready}, 128'd1);
      check("busy_rk10", round_key_10, vecs[0].rk10);

      // Restart from DONE: ready drops on the load edge, old result kept until the new one.
      start_key(vecs[1].key);
      check("restart_ready_drop", {127'd0, key_ready}, 128'd0);
      check("restart_rk10_kept", round_key_10, vecs[0].rk10);
      wait_result("restart", vecs[1].rk1, vecs[1].rk10);

      // Asynchronous reset mid-expansion.
      start_key(vecs[2].key);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_rk10", round_key_10, 128'd0);
      check("midrst_ready", {127'd0, key_ready}, 128'd0);
      check("midrst_busy", {127'd0, busy}, 128'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_idle_busy", {127'd0, busy}, 128'd0);
      check("midrst_idle_ready", {127'd0, key_ready}, 128'd0);
      start_key(vecs[0].key);
      wait_result("after_rst", vecs[0].rk1, vecs[0].rk10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
